// File: rtl/div_serial_arb_pkg.sv
// Shared types and helpers for the div_serial_arb slice: FSM state encoding
// and the requester-id width calculation.
package div_serial_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  function automatic int unsigned id_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/div_serial.sv
// Unsigned restoring serial divider: one quotient bit per cycle, DATA_W cycles
// after start. done stays high from completion until the next start.
module div_serial #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] rem_q;
  logic [DATA_W-1:0] quo_q;
  logic [DATA_W-1:0] dvs_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              done_q;

  logic [DATA_W:0]   shifted;
  logic [DATA_W-1:0] diff;
  logic              ge;

  // One restoring step; the extra top bit keeps the >= compare exact.
  always_comb begin
    shifted = {rem_q, quo_q[DATA_W-1]};
    ge      = (shifted >= {1'b0, dvs_q});
    diff    = shifted[DATA_W-1:0] - dvs_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else if (start) begin
      rem_q  <= '0;
      quo_q  <= dividend;
      dvs_q  <= divisor;
      cnt_q  <= CNT_W'(DATA_W);
      done_q <= 1'b0;
    end else if (cnt_q != '0) begin
      rem_q <= ge ? diff : shifted[DATA_W-1:0];
      quo_q <= {quo_q[DATA_W-2:0], ge};
      cnt_q <= cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        done_q <= 1'b1;
      end
    end
  end

  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/div_serial_arb.sv
// Round-robin front end sharing one div_serial core among N_REQ requesters;
// divide-by-zero is answered locally without starting the core.
module div_serial_arb
  import div_serial_arb_pkg::*;
#(
  parameter  int unsigned DATA_W = 32,
  parameter  int unsigned N_REQ  = 4,
  localparam int unsigned ID_W   = id_width(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*DATA_W-1:0] req_dividend,
  input  logic [N_REQ*DATA_W-1:0] req_divisor,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [DATA_W-1:0]       rsp_quotient,
  output logic [DATA_W-1:0]       rsp_remainder,
  output logic                    rsp_dz,
  output logic                    busy
);

  arb_state_t        state_q, state_d;
  logic [ID_W-1:0]   rr_q, rr_d;
  logic [DATA_W-1:0] opa_q, opa_d;
  logic [DATA_W-1:0] opb_q, opb_d;
  logic              rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_d;
  logic [DATA_W-1:0] rsp_quotient_d;
  logic [DATA_W-1:0] rsp_remainder_d;
  logic              rsp_dz_d;

  logic              gnt_found;
  logic [ID_W-1:0]   gnt_idx;
  logic [DATA_W-1:0] gnt_dividend;
  logic [DATA_W-1:0] gnt_divisor;

  logic              core_start;
  logic              core_done;
  logic [DATA_W-1:0] core_quo;
  logic [DATA_W-1:0] core_rem;

  // First valid requester at or after ptr, wrapping; MSB flags a hit.
  function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] v,
                                            input logic [ID_W-1:0]  ptr);
    logic [ID_W:0] r;
    int            idx;
    r = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      idx = (int'(ptr) + i) % int'(N_REQ);
      if (!r[ID_W] && v[idx]) begin
        r = {1'b1, ID_W'(idx)};
      end
    end
    return r;
  endfunction

  always_comb begin
    {gnt_found, gnt_idx} = rr_pick(req_valid, rr_q);
    gnt_dividend = req_dividend[int'(gnt_idx)*DATA_W +: DATA_W];
    gnt_divisor  = req_divisor[int'(gnt_idx)*DATA_W +: DATA_W];
  end

  // Next-state and datapath-register update.
  always_comb begin
    state_d         = state_q;
    rr_d            = rr_q;
    opa_d           = opa_q;
    opb_d           = opb_q;
    rsp_valid_d     = rsp_valid;
    rsp_id_d        = rsp_id;
    rsp_quotient_d  = rsp_quotient;
    rsp_remainder_d = rsp_remainder;
    rsp_dz_d        = rsp_dz;
    req_ready       = '0;
    core_start      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (gnt_found) begin
          req_ready[gnt_idx] = 1'b1;
          opa_d    = gnt_dividend;
          opb_d    = gnt_divisor;
          rsp_id_d = gnt_idx;
          rr_d     = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
          if (gnt_divisor == '0) begin
            rsp_quotient_d  = '1;
            rsp_remainder_d = gnt_dividend;
            rsp_dz_d        = 1'b1;
            rsp_valid_d     = 1'b1;
            state_d         = ST_RESP;
          end else begin
            state_d = ST_START;
          end
        end
      end
      ST_START: begin
        core_start = 1'b1;
        state_d    = ST_WAIT;
      end
      // done seen in START is left over from the previous divide, so only WAIT looks at it.
      ST_WAIT: begin
        if (core_done) begin
          rsp_quotient_d  = core_quo;
          rsp_remainder_d = core_rem;
          rsp_dz_d        = 1'b0;
          rsp_valid_d     = 1'b1;
          state_d         = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      rr_q          <= '0;
      opa_q         <= '0;
      opb_q         <= '0;
      rsp_valid     <= 1'b0;
      rsp_id        <= '0;
      rsp_quotient  <= '0;
      rsp_remainder <= '0;
      rsp_dz        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_q          <= rr_d;
      opa_q         <= opa_d;
      opb_q         <= opb_d;
      rsp_valid     <= rsp_valid_d;
      rsp_id        <= rsp_id_d;
      rsp_quotient  <= rsp_quotient_d;
      rsp_remainder <= rsp_remainder_d;
      rsp_dz        <= rsp_dz_d;
    end
  end

  assign busy = (state_q != ST_IDLE);

  div_serial #(
    .DATA_W (DATA_W)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (core_start),
    .dividend  (opa_q),
    .divisor   (opb_q),
    .done      (core_done),
    .quotient  (core_quo),
    .remainder (core_rem)
  );

endmodule

// File: tb/tb_div_serial_arb.sv
// Directed plus randomized bench for div_serial_arb against an arithmetic
// reference model (a/b, a%b, round-robin pointer).
module tb_div_serial_arb;

  localparam int unsigned DW = 32;
  localparam int unsigned N  = 4;
  localparam int unsigned IW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_dividend = '0;
  logic [N*DW-1:0] req_divisor = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b1;
  logic [IW-1:0]   rsp_id;
  logic [DW-1:0]   rsp_quotient;
  logic [DW-1:0]   rsp_remainder;
  logic            rsp_dz;
  logic            busy;

  div_serial_arb #(.DATA_W(DW), .N_REQ(N)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_dividend  (req_dividend),
    .req_divisor   (req_divisor),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_id        (rsp_id),
    .rsp_quotient  (rsp_quotient),
    .rsp_remainder (rsp_remainder),
    .rsp_dz        (rsp_dz),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int start_cnt = 0;

  always @(posedge clk) if (dut.core_start) start_cnt <= start_cnt + 1;

  // Requester-side view and reference model state.
  logic [N-1:0]  vld = '0;
  logic [DW-1:0] a_arr [N];
  logic [DW-1:0] b_arr [N];
  int            ptr_m = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive();
    req_valid = vld;
    for (int i = 0; i < int'(N); i++) begin
      req_dividend[i*DW +: DW] = a_arr[i];
      req_divisor[i*DW +: DW]  = b_arr[i];
    end
    #1;
  endtask

  task automatic set_op(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
    vld[i]   = 1'b1;
    a_arr[i] = a;
    b_arr[i] = b;
  endtask

  task automatic new_op(input int i);
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    a = $urandom;
    case ($urandom_range(0, 7))
      0:       b = '0;
      1, 2:    b = DW'($urandom_range(1, 15));
      3:       b = a;
      4:       b = a + DW'(1);
      default: b = $urandom;
    endcase
    set_op(i, a, b);
  endtask

  function automatic int exp_grant(input logic [N-1:0] v, input int p);
    for (int k = 0; k < int'(N); k++) begin
      if (v[(p + k) % int'(N)]) return (p + k) % int'(N);
    end
    return 0;
  endfunction

  task automatic do_reset();
    vld = '0;
    drive();
    rsp_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    ptr_m = 0;
    #1;
  endtask

  // One full transaction from the current IDLE state; hold = cycles rsp_ready stays low.
  task automatic one_op(input int hold, input bit refill);
    int            g, lat, n, s0;
    logic [N-1:0]  onehot;
    logic [DW-1:0] ea, eb, eq, er;
    logic          edz;
    rsp_ready = (hold == 0);
    #1;
    g = exp_grant(vld, ptr_m);
    onehot = '0;
    onehot[g] = 1'b1;
    n = 0;
    while (req_ready == '0 && n < 50) begin tick(); n++; end
    chk("grant_delay", 64'(n), 64'(0));
    chk("req_ready", 64'(req_ready), 64'(onehot));
    ea = a_arr[g];
    eb = b_arr[g];
    if (eb == '0) begin eq = '1; er = ea; edz = 1'b1; end
    else begin eq = ea / eb; er = ea % eb; edz = 1'b0; end
    s0 = start_cnt;
    tick();
    if (refill) new_op(g); else vld[g] = 1'b0;
    drive();
    ptr_m = (g + 1) % int'(N);
    lat = 0;
    while (!rsp_valid && lat < 200) begin tick(); lat++; end
    chk("latency", 64'(lat), (eb == '0) ? 64'(0) : 64'(DW + 2));
    chk("start_pulses", 64'(start_cnt - s0), (eb == '0) ? 64'(0) : 64'(1));
    chk("rsp_quotient", 64'(rsp_quotient), 64'(eq));
    chk("rsp_remainder", 64'(rsp_remainder), 64'(er));
    chk("rsp_dz", 64'(rsp_dz), 64'(edz));
    chk("rsp_id", 64'(rsp_id), 64'(g));
    chk("busy_resp", 64'(busy), 64'(1));
    chk("ready_resp", 64'(req_ready), 64'(0));
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("hold_valid", 64'(rsp_valid), 64'(1));
      chk("hold_quotient", 64'(rsp_quotient), 64'(eq));
      chk("hold_remainder", 64'(rsp_remainder), 64'(er));
      chk("hold_id", 64'(rsp_id), 64'(g));
      chk("hold_ready", 64'(req_ready), 64'(0));
      chk("hold_busy", 64'(busy), 64'(1));
    end
    rsp_ready = 1'b1;
    tick();
    chk("rsp_clear", 64'(rsp_valid), 64'(0));
    chk("busy_idle", 64'(busy), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < int'(N); i++) begin a_arr[i] = '0; b_arr[i] = '0; end

    // Async reset, sampled before any clock edge.
    #1 rst = 1'b1;
    #1;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_quotient", 64'(rsp_quotient), 64'(0));
    chk("rst_remainder", 64'(rsp_remainder), 64'(0));
    chk("rst_id_dz", 64'({rsp_id, rsp_dz}), 64'(0));
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;

    // Single divide, then local divide-by-zero.
    set_op(0, 32'd100, 32'd7); drive(); one_op(0, 1'b0);
    set_op(1, 32'h1234, 32'd0); drive(); one_op(0, 1'b0);

    // Boundary operands.
    set_op(2, 32'd5, 32'd9); drive(); one_op(0, 1'b0);
    set_op(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF); drive(); one_op(0, 1'b0);
    set_op(0, 32'd0, 32'd3); drive(); one_op(0, 1'b0);

    // Back-pressure on the response with another requester waiting.
    set_op(1, 32'd1000, 32'd33); set_op(2, 32'd77, 32'd0); drive();
    one_op(10, 1'b0);
    one_op(0, 1'b0);

    // Reset while the core is mid-divide.
    set_op(0, 32'd50, 32'd3); drive();
    tick();
    vld = '0; drive();
    repeat (5) tick();
    chk("wait_busy", 64'(busy), 64'(1));
    #2 rst = 1'b1;
    #1;
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    ptr_m = 0;
    #1;
    set_op(3, 32'hFFFF_FFFF, 32'd1); drive(); one_op(0, 1'b0);

    // All requesters continuously valid from a fresh pointer.
    do_reset();
    for (int i = 0; i < int'(N); i++) new_op(i);
    drive();
    for (int k = 0; k < 5; k++) one_op(0, 1'b1);

    // Randomized traffic.
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < int'(N); i++) begin
        if (!vld[i] && $urandom_range(0, 1) == 1) new_op(i);
      end
      if (vld == '0) new_op(int'($urandom_range(0, N - 1)));
      drive();
      one_op(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
